uart_rx_fifo: RTL and testbench

- Receive-side buffer between the buart receiver and the CPU IO page.
- Drains buart's single-byte holding register as soon as a byte arrives, so bursts at 115200 baud survive while firmware is busy (e.g. redrawing character RAM).
- Presents the oldest byte plus status to the IO read mux. Its pop strobe is the CPU read of the UART data register.

---
 rtl/uart_rx_fifo_pkg.sv | 33 +++
 rtl/uart_rx_fifo_sync_fifo_core.sv | 72 +++++++
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and constants for the UART receive FIFO
// Contents:
//   cap_state_e       capture FSM encoding (CAP_IDLE=0, CAP_GUARD=1)
//   *_DEF             default depth and RTS threshold
//   STAT_*            bit positions of the fields in the IO status word
//   status_word()     packs rd_valid, full and count[3:0] into that word
package uart_rx_fifo_pkg;

  localparam int DEPTH_LOG2_DEF    = 4;
  localparam int RTS_THRESHOLD_DEF = 12;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_GUARD = 1'b1
  } cap_state_e;

  localparam int STAT_RD_VALID_BIT = 8;
  localparam int STAT_FULL_BIT     = 9;
  localparam int STAT_COUNT_LSB    = 12;
  localparam int STAT_COUNT_MSB    = 15;

  function automatic logic [15:0] status_word(input logic       rd_valid,
                                              input logic       full,
                                              input logic [3:0] cnt);
    logic [15:0] w;
    w = '0;
    w[STAT_RD_VALID_BIT] = rd_valid;
    w[STAT_FULL_BIT]     = full;
    w[STAT_COUNT_MSB:STAT_COUNT_LSB] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo_core.sv
// rtl/uart_rx_fifo_sync_fifo_core.sv - flop-based synchronous FIFO storage, pointers and count
// Ports:
//   clk, reset         clock, synchronous active-high reset (pointers/count only)
//   push, push_data    write request and byte; ignored while full
//   pop                read request; ignored while empty
//   rd_data            head entry, zero when empty
//   rd_valid, full     not-empty / count at depth, both from the registered count
//   count              occupancy 0..2**DEPTH_LOG2
module sync_fifo_core #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full     = (count_q == DEPTH_CNT);
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && rd_valid;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; empty is signalled by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO draining the buart holding register for the CPU IO page
// Optional feature macro: UART_RX_FIFO_RTS_EN (adds registered rts_n flow-control output)
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   uart_valid          buart holds a received byte
//   uart_rx_data        that byte
//   uart_rd             one-cycle acknowledge to buart, combinational in the capture cycle
//   cpu_rd              CPU read of the UART data register (pop)
//   rd_data             oldest byte, 0x00 when empty
//   rd_valid, full      FIFO not empty / FIFO at depth
//   count               occupancy 0..2**DEPTH_LOG2
//   rts_n               (UART_RX_FIFO_RTS_EN only) 1 when next count >= RTS_THRESHOLD
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2    = DEPTH_LOG2_DEF,
  parameter int RTS_THRESHOLD = RTS_THRESHOLD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_valid,
  input  logic [7:0]            uart_rx_data,
  output logic                  uart_rd,
  input  logic                  cpu_rd,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic                  rts_n
`endif
);

  cap_state_e state_q, state_d;
  logic       push;

  // buart still shows valid on the edge after rd, so one GUARD cycle must
  // pass before the next capture. Reset gates the acknowledge so a byte
  // caught on a reset edge stays in buart.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (uart_valid && !full && !reset) begin
          push    = 1'b1;
          state_d = CAP_GUARD;
        end
      end
      CAP_GUARD: state_d = CAP_IDLE;
      default:   state_d = CAP_IDLE;
    endcase
  end

  assign uart_rd = push;

  always_ff @(posedge clk) begin
    if (reset) state_q <= CAP_IDLE;
    else       state_q <= state_d;
  end

  sync_fifo_core #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (uart_rx_data),
    .pop       (cpu_rd),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .full      (full)
  );

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [DEPTH_LOG2:0] RTS_THR = (DEPTH_LOG2 + 1)'(RTS_THRESHOLD);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [DEPTH_LOG2:0] count_nx;
  logic                rts_n_q, rts_n_d;

  // Mirrors the core's count update so rts_n tracks count on the same edge.
  always_comb begin
    count_nx = count;
    case ({push, cpu_rd && rd_valid})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
    rts_n_d = (count_nx >= RTS_THR);
  end

  always_ff @(posedge clk) begin
    if (reset) rts_n_q <= 1'b0;
    else       rts_n_q <= rts_n_d;
  end

  assign rts_n = rts_n_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_rd;
  logic       cpu_rd = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
`ifdef UART_RX_FIFO_RTS_EN
  logic       rts_n;
`endif

  int err = 0;
  int chk = 0;

  uart_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .uart_valid   (uart_valid),
    .uart_rx_data (uart_rx_data),
    .uart_rd      (uart_rd),
    .cpu_rd       (cpu_rd),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full)
`ifdef UART_RX_FIFO_RTS_EN
    ,
    .rts_n        (rts_n)
`endif
  );

  always #5 clk = ~clk;

  // One cycle: drive on the falling edge, settle, leave the rising edge to commit.
  task automatic step(input logic v, input logic [7:0] d, input logic rd);
    @(negedge clk);
    reset = 1'b0;
    uart_valid = v;
    uart_rx_data = d;
    cpu_rd = rd;
    #1;
  endtask

  task automatic step_rst(input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = 1'b1;
    uart_valid = v;
    uart_rx_data = d;
    cpu_rd = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    step_rst(1'b0, 8'h00);
    step_rst(1'b0, 8'h00);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL reset_count got=%0d exp=0", count); end
    chk++; if (rd_valid !== 1'b0) begin err++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    chk++; if (full !== 1'b0) begin err++; $display("FAIL reset_full got=%0b exp=0", full); end
    chk++; if (rd_data !== 8'h00) begin err++; $display("FAIL reset_rd_data got=%02h exp=00", rd_data); end
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL reset_uart_rd got=%0b exp=0", uart_rd); end
`ifdef UART_RX_FIFO_RTS_EN
    chk++; if (rts_n !== 1'b0) begin err++; $display("FAIL reset_rts_n got=%0b exp=0", rts_n); end
`endif
  endtask

  task automatic test_single;
    step(1'b1, 8'h41, 1'b0);
    chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL single_uart_rd got=%0b exp=1", uart_rd); end
    chk++; if (rd_valid !== 1'b0) begin err++; $display("FAIL single_pre_valid got=%0b exp=0", rd_valid); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL single_uart_rd_once got=%0b exp=0", uart_rd); end
    chk++; if (rd_valid !== 1'b1) begin err++; $display("FAIL single_rd_valid got=%0b exp=1", rd_valid); end
    chk++; if (rd_data !== 8'h41) begin err++; $display("FAIL single_rd_data got=%02h exp=41", rd_data); end
    chk++; if (count !== 5'd1) begin err++; $display("FAIL single_count got=%0d exp=1", count); end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    chk++; if (rd_data !== 8'h00) begin err++; $display("FAIL single_pop_rd_data got=%02h exp=00", rd_data); end
  endtask

  task automatic test_linger;
    step(1'b1, 8'h55, 1'b0);
    chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL linger_first_rd got=%0b exp=1", uart_rd); end
    step(1'b1, 8'h66, 1'b0);
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL linger_guard_rd got=%0b exp=0", uart_rd); end
    step(1'b1, 8'h66, 1'b0);
    chk++; if (count !== 5'd1) begin err++; $display("FAIL linger_count1 got=%0d exp=1", count); end
    chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL linger_second_rd got=%0b exp=1", uart_rd); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd2) begin err++; $display("FAIL linger_count2 got=%0d exp=2", count); end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (rd_data !== 8'h55) begin err++; $display("FAIL linger_data0 got=%02h exp=55", rd_data); end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (rd_data !== 8'h66) begin err++; $display("FAIL linger_data1 got=%02h exp=66", rd_data); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL linger_empty got=%0d exp=0", count); end
  endtask

  task automatic test_fill_and_full_pop;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b1, 8'hAA, 1'b0);
    chk++; if (count !== 5'd16) begin err++; $display("FAIL fill_count got=%0d exp=16", count); end
    chk++; if (full !== 1'b1) begin err++; $display("FAIL fill_full got=%0b exp=1", full); end
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL fill_17th_rd got=%0b exp=0", uart_rd); end
    step(1'b1, 8'hAA, 1'b0);
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL fill_hold_rd got=%0b exp=0", uart_rd); end
    step(1'b1, 8'hAA, 1'b1);
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL fullpop_rd got=%0b exp=0", uart_rd); end
    chk++; if (rd_data !== 8'h00) begin err++; $display("FAIL fullpop_head got=%02h exp=00", rd_data); end
    step(1'b1, 8'hAA, 1'b0);
    chk++; if (count !== 5'd15) begin err++; $display("FAIL fullpop_count got=%0d exp=15", count); end
    chk++; if (full !== 1'b0) begin err++; $display("FAIL fullpop_full got=%0b exp=0", full); end
    chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL fullpop_late_rd got=%0b exp=1", uart_rd); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd16) begin err++; $display("FAIL fullpop_refill got=%0d exp=16", count); end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk++; if (rd_data !== 8'(i)) begin err++; $display("FAIL fill_order idx=%0d got=%02h exp=%02h", i, rd_data, 8'(i)); end
    end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (rd_data !== 8'hAA) begin err++; $display("FAIL fill_last got=%02h exp=AA", rd_data); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (rd_valid !== 1'b0) begin err++; $display("FAIL fill_drained got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_pop_empty;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    chk++; if (rd_data !== 8'h00) begin err++; $display("FAIL empty_pop_data got=%02h exp=00", rd_data); end
  endtask

  task automatic test_wrap_concurrent;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h80 + 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
    chk++; if (count !== 5'd10) begin err++; $display("FAIL wrap_count10 got=%0d exp=10", count); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk++; if (rd_data !== 8'h80 + 8'(i)) begin err++; $display("FAIL wrap_order idx=%0d got=%02h exp=%02h", i, rd_data, 8'h80 + 8'(i)); end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b1);
      chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL conc_rd idx=%0d got=%0b exp=1", i, uart_rd); end
      if (i > 0) begin
        chk++; if (rd_data !== 8'hC0 + 8'(i - 1)) begin err++; $display("FAIL conc_data idx=%0d got=%02h exp=%02h", i, rd_data, 8'hC0 + 8'(i - 1)); end
      end
      step(1'b0, 8'h00, 1'b0);
      chk++; if (count !== 5'd1) begin err++; $display("FAIL conc_count idx=%0d got=%0d exp=1", i, count); end
    end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (rd_data !== 8'hC9) begin err++; $display("FAIL conc_last got=%02h exp=C9", rd_data); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL conc_empty got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid_fill;
`ifdef UART_RX_FIFO_RTS_EN
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      if (i == 10) begin
        chk++; if (rts_n !== 1'b0) begin err++; $display("FAIL rts_at11 got=%0b exp=0", rts_n); end
      end
    end
    chk++; if (rts_n !== 1'b1) begin err++; $display("FAIL rts_at12 got=%0b exp=1", rts_n); end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (rts_n !== 1'b1) begin err++; $display("FAIL rts_pop_same got=%0b exp=1", rts_n); end
    step(1'b0, 8'h00, 1'b1);
    chk++; if (count !== 5'd11) begin err++; $display("FAIL rts_count11 got=%0d exp=11", count); end
    chk++; if (rts_n !== 1'b0) begin err++; $display("FAIL rts_release got=%0b exp=0", rts_n); end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`else
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
    end
`endif
    chk++; if (count !== 5'd7) begin err++; $display("FAIL mid_count7 got=%0d exp=7", count); end
    step_rst(1'b1, 8'h77);
    chk++; if (uart_rd !== 1'b0) begin err++; $display("FAIL mid_rst_uart_rd got=%0b exp=0", uart_rd); end
    step(1'b1, 8'h77, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    chk++; if (rd_valid !== 1'b0) begin err++; $display("FAIL mid_rst_valid got=%0b exp=0", rd_valid); end
`ifdef UART_RX_FIFO_RTS_EN
    chk++; if (rts_n !== 1'b0) begin err++; $display("FAIL mid_rst_rts got=%0b exp=0", rts_n); end
`endif
    chk++; if (uart_rd !== 1'b1) begin err++; $display("FAIL mid_recapture_rd got=%0b exp=1", uart_rd); end
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd1) begin err++; $display("FAIL mid_recapture_count got=%0d exp=1", count); end
    chk++; if (rd_data !== 8'h77) begin err++; $display("FAIL mid_recapture_data got=%02h exp=77", rd_data); end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk++; if (count !== 5'd0) begin err++; $display("FAIL mid_final_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_linger;
    test_fill_and_full_pop;
    test_pop_empty;
    test_wrap_concurrent;
    test_reset_mid_fill;
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
